neuron_layer_seq: RTL
=====================

# neuron_layer_seq

Sequencer that evaluates a layer of M threshold neurons, each with N binary synapses, on one shared serial accumulate-and-compare datapath. Weights are read one per cycle from an external synchronous weight memory. For each neuron, the weights of set synapse bits are summed and the sum is compared with that neuron's threshold. The block sits between the spike-input stage and the next layer and replaces M parallel combinational neurons with one time-multiplexed unit.

## Interface
- N, 8, synapses per neuron (≥1)
- M, 4, neurons in the layer (≥1)
- W, 32, weight/threshold/sum width
- AW, $clog2(M*N) (min 1), weight address width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request evaluation; accepted only in IDLE
- synapses  in  N  input spike vector, latched on accepted start
- thresholds  in  M*W  packed thresholds, neuron m at [m*W +: W]; must be held stable while busy
- w_en  out  1  weight memory read enable
- w_addr  out  AW  read address = m*N + i
- w_data  in  W  read data, valid exactly 1 cycle after w_en
- busy  out  1  high from the cycle after an accepted start until done falls
- done  out  1  one-cycle pulse, result valid
- axons  out  M  neuron outputs, held until next done

## Operation
- States:
  - IDLE: start=1 → latch synapses, idx=0, acc=0 → FETCH.
  - FETCH: drive w_en=1, w_addr=idx, idx++. When idx=M*N-1 is issued → DRAIN.
  - DRAIN: accumulate the last word and compare → DONE.
  - DONE: done=1, transfer the shadow register to axons → IDLE.
- Accumulate:
  - Each cycle after a read, term = syn_q[i_d] ? w_data : 0, where i_d is the synapse index of the address issued the previous cycle.
  - acc_next = acc + term, unsigned, modulo 2^W. Overflow wraps silently; there is no saturation.
- Compare:
  - Triggered on the term with i_d=N-1 of neuron m_d.
  - shadow[m_d] = (acc_next >= thresholds[m_d]), unsigned compare; acc then clears to 0.
  - Neuron boundaries are back-to-back with no bubble.
- Start while busy (FETCH/DRAIN/DONE) is ignored and not queued.
- Outputs:
  - axons changes only on the edge entering IDLE from DONE.
  - All M bits update together; intermediate shadow values are never visible.

## Timing
- Reset values: w_en=0, w_addr=0, busy=0, done=0, axons=0, state=IDLE, acc=0.
- Edge E0 samples start=1:
  - w_en is high for the M*N cycles following E0 (addresses 0..M*N-1 in order).
  - Last data is accumulated at edge E(M*N+1).
  - done is high for the one cycle after E(M*N+1).
  - Latency from start to done is M*N+1 cycles.
  - The earliest next accepted start is the edge after done falls, giving a period of M*N+3.
- rst_n low at any time, including mid-FETCH: all state and outputs return to reset values immediately. Any in-flight read data is ignored. No done is produced.
- Degenerate N=1: each read completes a neuron; compare every cycle.
- Zero synapses set: sum=0, so axon=1 only if the threshold is 0.

## Structure
- Shared package neuron_pkg:
  - state enum {IDLE, FETCH, DRAIN, DONE}
  - default W constant
  - a function for AW
- Sub-module neuron_mac:
  - 1-cycle-delayed index/valid pipeline
  - conditional accumulate
  - compare-and-clear
  - shadow write port
- The top level holds the FSM, address counter, synapse latch and output register.

## Test plan
- N=4, M=2, all weights=1, synapses=4'b1011, thresholds={3,4} → done 9 cycles after start; axons=2'b01.
- Weights 0x8000_0000 on two set synapses, threshold 1 → acc wraps to 0; axon=0.
- synapses=0, thresholds={0,1} → axons=2'b01; w_en is still high for exactly M*N cycles with addresses 0..7.
- start held high continuously → evaluations spaced 11 cycles apart, done each time; starts during busy are ignored.
- rst_n pulsed low at the 3rd FETCH cycle → all outputs 0 asynchronously, no done; a fresh start completes normally with correct axons.
- synapses changed while busy → result uses the start-time vector only.

Source files
------------

// File: rtl/neuron_pkg.sv
// ============================================================================
// neuron_pkg : shared types and helpers for the serial neuron layer sequencer
// Revision   : 1.0
// ============================================================================
`default_nettype none

package neuron_pkg;

  localparam int unsigned c_def_w = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Address/index width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/neuron_layer_seq_if.sv
// ============================================================================
// neuron_layer_seq_if : control, spike and weight-memory bus of the layer
// Revision            : 1.0
// ============================================================================
`default_nettype none

interface neuron_layer_seq_if
  import neuron_pkg::*;
#(
  parameter int N  = 8,
  parameter int M  = 4,
  parameter int W  = c_def_w,
  parameter int AW = clog2_min1(M * N)
);

  logic             start;
  logic [N-1:0]     synapses;
  logic [M*W-1:0]   thresholds;
  logic             w_en;
  logic [AW-1:0]    w_addr;
  logic [W-1:0]     w_data;
  logic             busy;
  logic             done;
  logic [M-1:0]     axons;

  modport master (
    input  start, synapses, thresholds, w_data,
    output w_en, w_addr, busy, done, axons
  );

  modport slave (
    output start, synapses, thresholds, w_data,
    input  w_en, w_addr, busy, done, axons
  );

endinterface

`default_nettype wire

// File: rtl/neuron_mac.sv
// ============================================================================
// neuron_mac : delayed-index accumulate, compare-and-clear and shadow result
// Revision   : 1.0
// ============================================================================
`default_nettype none

module neuron_mac
  import neuron_pkg::*;
#(
  parameter int N  = 8,
  parameter int M  = 4,
  parameter int W  = c_def_w,
  parameter int IW = clog2_min1(N),
  parameter int MW = clog2_min1(M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             issue_v,
  input  logic [IW-1:0]    issue_i,
  input  logic [MW-1:0]    issue_m,
  input  logic [N-1:0]     syn,
  input  logic [M*W-1:0]   thresholds,
  input  logic [W-1:0]     w_data,
  output logic [M-1:0]     shadow
);

  logic            r_vd;
  logic [IW-1:0]   r_id;
  logic [MW-1:0]   r_md;
  logic [W-1:0]    r_acc;
  logic [M-1:0]    r_shadow;

  logic [W-1:0]    w_term;
  logic [W-1:0]    w_acc_next;
  logic [W-1:0]    w_thr;
  logic            w_last;

  // r_vd/r_id/r_md describe the read whose data is on w_data this cycle.
  assign w_term     = (r_vd && syn[r_id]) ? w_data : '0;
  assign w_acc_next = r_acc + w_term;
  assign w_thr      = thresholds[r_md*W +: W];
  assign w_last     = r_vd && (r_id == IW'(N - 1));
  assign shadow     = r_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vd     <= 1'b0;
      r_id     <= '0;
      r_md     <= '0;
      r_acc    <= '0;
      r_shadow <= '0;
    end else begin
      r_vd <= issue_v;
      r_id <= issue_i;
      r_md <= issue_m;
      if (clr) begin
        r_acc <= '0;
      end else if (r_vd) begin
        r_acc <= w_last ? '0 : w_acc_next;
      end
      if (w_last) begin
        r_shadow[r_md] <= (w_acc_next >= w_thr);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/neuron_layer_seq.sv
// ============================================================================
// neuron_layer_seq : time-multiplexed layer of M threshold neurons (N synapses)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module neuron_layer_seq
  import neuron_pkg::*;
#(
  parameter int N  = 8,
  parameter int M  = 4,
  parameter int W  = c_def_w,
  parameter int AW = clog2_min1(M * N)
) (
  input  logic               clk,
  input  logic               rst_n,
  neuron_layer_seq_if.master bus
);

  localparam int IW = clog2_min1(N);
  localparam int MW = clog2_min1(M);
  localparam logic [AW-1:0] c_last_addr = AW'(M * N - 1);
  localparam logic [IW-1:0] c_last_i    = IW'(N - 1);

  state_t          r_state;
  logic            r_w_en;
  logic [AW-1:0]   r_w_addr;
  logic [IW-1:0]   r_i;
  logic [MW-1:0]   r_m;
  logic [N-1:0]    r_syn;
  logic            r_busy;
  logic            r_done;
  logic [M-1:0]    r_axons;

  logic            w_accept;
  logic [M-1:0]    w_shadow;

  assign w_accept = (r_state == IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_w_en   <= 1'b0;
      r_w_addr <= '0;
      r_i      <= '0;
      r_m      <= '0;
      r_syn    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_axons  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_syn    <= bus.synapses;
            r_w_en   <= 1'b1;
            r_w_addr <= '0;
            r_i      <= '0;
            r_m      <= '0;
            r_busy   <= 1'b1;
            r_state  <= FETCH;
          end
        end
        FETCH: begin
          if (r_w_addr == c_last_addr) begin
            r_w_en  <= 1'b0;
            r_state <= DRAIN;
          end else begin
            r_w_addr <= r_w_addr + 1'b1;
            if (r_i == c_last_i) begin
              r_i <= '0;
              r_m <= r_m + 1'b1;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end
        end
        DRAIN: begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          // Axons update only here so partial shadow results never leak out.
          r_axons <= w_shadow;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  neuron_mac #(
    .N  (N),
    .M  (M),
    .W  (W),
    .IW (IW),
    .MW (MW)
  ) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (w_accept),
    .issue_v    (r_w_en),
    .issue_i    (r_i),
    .issue_m    (r_m),
    .syn        (r_syn),
    .thresholds (bus.thresholds),
    .w_data     (bus.w_data),
    .shadow     (w_shadow)
  );

  assign bus.w_en   = r_w_en;
  assign bus.w_addr = r_w_addr;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.axons  = r_axons;

endmodule

`default_nettype wire
